rs232_tx_arbiter: RTL and testbench

//  Shares one RS232 byte transmitter (tx_start/tx_finish handshake) among N_REQ frame requesters.

---
 rtl/rs232_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/rs232_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 transmit arbiter and the frame builders around it.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SEND,
    WAIT,
    FIN,
    ABORT
  } tx_arb_state_t;

  // Frame delimiters used by upstream frame builders
  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, cyclically.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned OW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [OW-1:0]    gnt_idx_c,
  output logic             gnt_valid_c
);

  logic [OW-1:0] idx;

  always_comb begin
    gnt_idx_c   = '0;
    gnt_valid_c = 1'b0;
    idx         = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = OW'((32'(ptr) + i) % N_REQ);
      if (!gnt_valid_c && req[idx]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = idx;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Shares one RS232 byte transmitter among N_REQ frame requesters: round-robin grant,
// frame latch at grant, byte-by-byte tx_start/tx_finish handshake with timeout abort.
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned FRAME_BYTES = 4,
  parameter int unsigned TIMEOUT     = 65535,
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1,
  localparam int unsigned CW = $clog2(FRAME_BYTES) + 1,
  localparam int unsigned TW = $clog2(TIMEOUT + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*FRAME_BYTES*8-1:0] frame_data,
  output logic [N_REQ-1:0]               done,
  output logic [N_REQ-1:0]               err,
  output logic                           busy,
  output logic [OW-1:0]                  owner,
  output logic [7:0]                     tx_data,
  output logic                           tx_start,
  input  logic                           tx_finish
);

  tx_arb_state_t state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  rr_q, rr_d;
  logic [FRAME_BYTES-1:0][7:0] buf_q, buf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;
  logic           busy_q, busy_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;

  logic [N_REQ-1:0][FRAME_BYTES-1:0][7:0] frames_c;
  logic [OW-1:0] arb_idx_c;
  logic          arb_valid_c;

  assign frames_c = frame_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req         (req),
    .ptr         (rr_q),
    .gnt_idx_c   (arb_idx_c),
    .gnt_valid_c (arb_valid_c)
  );

  // tx_start/tx_data register on the SEND edge; done/err/busy reflect the state being entered
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = '0;
    err_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid_c) begin
          owner_d = arb_idx_c;
          state_d = GRANT;
        end
      end
      GRANT: begin
        buf_d   = frames_c[owner_q];
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        tx_data_d  = buf_q[cnt_q[BW-1:0]];
        tx_start_d = 1'b1;
        tmo_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tx_finish) begin
          if (cnt_q == CW'(FRAME_BYTES - 1)) begin
            state_d = FIN;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = SEND;
          end
        end else begin
          if (tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT)) state_d = ABORT;
        end
      end
      FIN, ABORT: begin
        rr_d    = OW'((32'(owner_q) + 32'd1) % N_REQ);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    if (state_d == FIN)   done_d = N_REQ'(1) << owner_q;
    if (state_d == ABORT) err_d  = N_REQ'(1) << owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      buf_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: latency, byte order, round-robin, timeout, reset, stray tx_finish.
module tb_rs232_tx_arbiter;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned FB    = 4;
  localparam int unsigned TMO   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] frame_data;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        busy;
  logic [0:0]  owner;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_finish;
  logic        auto_fin;
  logic        stray_fin;

  int tests = 0;
  int fails = 0;
  int fin_cnt;
  int auto_left;

  logic [7:0] byte_log [$];
  logic [1:0] done_log [$];
  logic [1:0] err_log  [$];

  logic [7:0] exp_b [8] = '{8'h02, 8'h3A, 8'h35, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_e [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

  assign tx_finish = auto_fin | stray_fin;

  rs232_tx_arbiter #(.N_REQ(N_REQ), .FRAME_BYTES(FB), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .frame_data (frame_data),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .owner      (owner),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_finish  (tx_finish)
  );

  always #5 clk = ~clk;

  // Transmitter model: answers tx_finish 10 cycles after each tx_start while auto_left > 0
  initial begin
    auto_fin = 1'b0;
    fin_cnt  = 0;
    forever begin
      @(negedge clk);
      auto_fin = 1'b0;
      if (rst === 1'b1) begin
        fin_cnt = 0;
      end else if (tx_start === 1'b1 && auto_left > 0) begin
        fin_cnt   = 10;
        auto_left = auto_left - 1;
      end else if (fin_cnt > 0) begin
        fin_cnt = fin_cnt - 1;
        if (fin_cnt == 0) auto_fin = 1'b1;
      end
    end
  end

  // Event logger
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) byte_log.push_back(tx_data);
      if (done !== 2'b00) done_log.push_back(done);
      if (err !== 2'b00) err_log.push_back(err);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (n < 200) begin
      tick(1);
      n++;
      if (tx_start === 1'b1) break;
    end
    chk({tag, "_start_seen"}, 64'(tx_start), 64'd1);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (n < 400) begin
      tick(1);
      n++;
      if (done !== 2'b00 || err !== 2'b00) break;
    end
    chk({tag, "_end_seen"}, 64'((done !== 2'b00) || (err !== 2'b00)), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"},     64'(done),     64'h0);
    chk({tag, "_err"},      64'(err),      64'h0);
    chk({tag, "_busy"},     64'(busy),     64'h0);
    chk({tag, "_owner"},    64'(owner),    64'h0);
    chk({tag, "_tx_data"},  64'(tx_data),  64'h0);
    chk({tag, "_tx_start"}, 64'(tx_start), 64'h0);
  endtask

  task automatic clear_logs();
    byte_log.delete();
    done_log.delete();
    err_log.delete();
  endtask

  initial begin
    rst        = 1'b1;
    req        = 2'b00;
    frame_data = {32'h44332211, 32'h03353A02};
    stray_fin  = 1'b0;
    auto_left  = 1000;
    tick(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick(1);
    clear_logs();

    // Single requester 0: latency, byte order, gap, done, busy fall
    req = 2'b01;
    tick(1);
    chk("A_owner", 64'(owner), 64'h0);
    chk("A_busy_grant", 64'(busy), 64'h1);
    req = 2'b00;
    tick(1);
    chk("A_no_start_yet", 64'(tx_start), 64'h0);
    tick(1);
    chk("A_latency", 64'(tx_start), 64'h1);
    chk("A_byte0", 64'(tx_data), 64'h02);
    tick(11);
    chk("A_gap_quiet", 64'(tx_start), 64'h0);
    tick(1);
    chk("A_gap", 64'(tx_start), 64'h1);
    chk("A_byte1", 64'(tx_data), 64'h3A);
    wait_end("A");
    chk("A_done", 64'(done), 64'h1);
    chk("A_err", 64'(err), 64'h0);
    chk("A_busy_done", 64'(busy), 64'h1);
    tick(1);
    chk("A_busy_fall", 64'(busy), 64'h0);
    chk("A_done_pulse", 64'(done), 64'h0);
    tick(2);
    chk("A_nbytes", 64'(byte_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("A_bytes", 64'(byte_log[k]), 64'(exp_b[k]));
    chk("A_ndone", 64'(done_log.size()), 64'd1);

    // Both requesters from reset: 0 first then 1, back-to-back
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    clear_logs();
    req = 2'b11;
    tick(1);
    chk("B_owner_first", 64'(owner), 64'h0);
    wait_end("B0");
    chk("B_first_done", 64'(done), 64'h1);
    req = 2'b10;
    tick(1);
    chk("B_idle_gap", 64'(busy), 64'h0);
    tick(1);
    chk("B_owner_second", 64'(owner), 64'h1);
    chk("B_busy_second", 64'(busy), 64'h1);
    wait_end("B1");
    chk("B_second_done", 64'(done), 64'h2);
    req = 2'b00;
    tick(2);
    chk("B_nbytes", 64'(byte_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) chk("B_bytes", 64'(byte_log[k]), 64'(exp_b[k]));
    chk("B_ndone", 64'(done_log.size()), 64'd2);
    chk("B_done_order0", 64'(done_log[0]), 64'h1);
    chk("B_done_order1", 64'(done_log[1]), 64'h2);

    // Fairness: req[0] held, req[1] raised mid-frame -> 0,1,0
    clear_logs();
    req = 2'b01;
    tick(3);
    req = 2'b11;
    wait_end("C0");
    chk("C_done0", 64'(done), 64'h1);
    tick(2);
    chk("C_owner_1", 64'(owner), 64'h1);
    req = 2'b01;
    wait_end("C1");
    chk("C_done1", 64'(done), 64'h2);
    tick(2);
    chk("C_owner_back", 64'(owner), 64'h0);
    req = 2'b00;
    wait_end("C2");
    chk("C_done2", 64'(done), 64'h1);
    tick(2);
    chk("C_ndone", 64'(done_log.size()), 64'd3);

    // Timeout: byte 1 never finished -> err 20 cycles after its tx_start
    clear_logs();
    auto_left = 1;
    req = 2'b01;
    tick(1);
    req = 2'b00;
    wait_start("D0");
    wait_start("D1");
    chk("D_byte1", 64'(tx_data), 64'h3A);
    tick(19);
    chk("D_no_err_early", 64'(err), 64'h0);
    tick(1);
    chk("D_err", 64'(err), 64'h1);
    chk("D_no_done", 64'(done), 64'h0);
    chk("D_busy_abort", 64'(busy), 64'h1);
    tick(1);
    chk("D_idle", 64'(busy), 64'h0);
    chk("D_err_pulse", 64'(err), 64'h0);
    auto_left = 1000;
    clear_logs();
    req = 2'b01;
    tick(1);
    req = 2'b00;
    wait_end("D_next");
    chk("D_next_done", 64'(done), 64'h1);
    tick(2);
    chk("D_next_nbytes", 64'(byte_log.size()), 64'd4);
    chk("D_next_nerr", 64'(err_log.size()), 64'd0);

    // Stray tx_finish in IDLE/GRANT, frame_data changed after latch
    clear_logs();
    stray_fin = 1'b1;
    tick(1);
    stray_fin = 1'b0;
    req = 2'b01;
    frame_data[31:0] = 32'hA1B2C3D4;
    tick(1);
    stray_fin = 1'b1;
    req = 2'b00;
    tick(1);
    stray_fin = 1'b0;
    frame_data[31:0] = 32'hFFFFFFFF;
    wait_end("E");
    chk("E_done", 64'(done), 64'h1);
    tick(2);
    chk("E_nbytes", 64'(byte_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("E_bytes", 64'(byte_log[k]), 64'(exp_e[k]));
    frame_data[31:0] = 32'h03353A02;

    // Reset during WAIT of byte 2, then a fresh frame from byte 0
    clear_logs();
    req = 2'b10;
    tick(1);
    req = 2'b00;
    wait_start("F0");
    wait_start("F1");
    wait_start("F2");
    chk("F_byte2", 64'(tx_data), 64'h33);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("F_reset");
    rst = 1'b0;
    tick(30);
    chk("F_no_done", 64'(done_log.size()), 64'd0);
    chk("F_no_err", 64'(err_log.size()), 64'd0);
    byte_log.delete();
    req = 2'b10;
    tick(1);
    req = 2'b00;
    wait_start("F_fresh");
    chk("F_fresh_byte0", 64'(tx_data), 64'h11);
    wait_end("F_fresh");
    chk("F_fresh_done", 64'(done), 64'h2);
    tick(2);
    chk("F_fresh_nbytes", 64'(byte_log.size()), 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
